// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory bus.
// Accepts one request at a time, waits LATENCY cycles, then commits the
// access to a word-organised, byte-maskable RAM and pulses mem_valid.
// All outputs come straight from flops.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        mem_rd_wr,
    input  logic [3:0]  mask,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_valid,
    output logic        busy
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]            r_cnt;
    logic                  r_rd_wr;
    logic [3:0]            r_mask;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_inrange;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_valid;
    logic                  r_busy;

    logic [31:0]           r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] w_in_idx;
    logic                  w_in_range;
    logic                  w_src_idle;
    logic                  w_c_rd_wr;
    logic [3:0]            w_c_mask;
    logic [DEPTH_LOG2-1:0] w_c_idx;
    logic                  w_c_inrange;
    logic [31:0]           w_c_wdata;
    logic                  w_enter_resp;
    logic                  w_we;
    logic                  w_unused_addr;

    // Decode the live request: word index and whether the upper address bits are clear.
    assign w_in_idx      = mem_addr[DEPTH_LOG2+1:2];
    assign w_in_range    = (mem_addr[31:DEPTH_LOG2+2] == '0);
    assign w_unused_addr = ^mem_addr[1:0];

    // With LATENCY==0 the commit edge is the acceptance edge, so the
    // latched copy isn't there yet; take the live inputs in that case.
    assign w_src_idle  = (r_state == S_IDLE);
    assign w_c_rd_wr   = w_src_idle ? mem_rd_wr      : r_rd_wr;
    assign w_c_mask    = w_src_idle ? mask           : r_mask;
    assign w_c_idx     = w_src_idle ? w_in_idx       : r_idx;
    assign w_c_inrange = w_src_idle ? w_in_range     : r_inrange;
    assign w_c_wdata   = w_src_idle ? mem_write_data : r_wdata;

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    // Gate with reset so an edge seen while reset is held never writes.
    assign w_we = reset && w_enter_resp && !w_c_rd_wr && w_c_inrange;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: WAIT lasts LATENCY cycles, RESP exactly one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cs) w_next = (LAT == 4'd0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch and wait counter; inputs are only looked at in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 4'd0;
            r_rd_wr   <= 1'b0;
            r_mask    <= 4'd0;
            r_idx     <= '0;
            r_inrange <= 1'b0;
            r_wdata   <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (cs) begin
                r_cnt     <= LAT;
                r_rd_wr   <= mem_rd_wr;
                r_mask    <= mask;
                r_idx     <= w_in_idx;
                r_inrange <= w_in_range;
                r_wdata   <= mem_write_data;
            end
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Registered outputs track the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_valid <= (w_next == S_RESP);
            r_busy  <= (w_next != S_IDLE);
            if (w_enter_resp && w_c_rd_wr)
                r_rdata <= w_c_inrange ? r_mem[w_c_idx] : 32'd0;
        end
    end

    // Byte-masked RAM write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_c_mask[i]) r_mem[w_c_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
            end
        end
    end

    assign mem_read_data = r_rdata;
    assign mem_valid     = r_valid;
    assign busy          = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 (table of
// requests) and one at LATENCY=0 (back-to-back), plus reset corner cases.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_cs = 1'b0, a_rd = 1'b0;
    logic [3:0]  a_mask = 4'h0;
    logic [31:0] a_addr = 32'h0, a_wd = 32'h0, a_rdata;
    logic        a_valid, a_busy;

    logic        b_cs = 1'b0, b_rd = 1'b0;
    logic [3:0]  b_mask = 4'h0;
    logic [31:0] b_addr = 32'h0, b_wd = 32'h0, b_rdata;
    logic        b_valid, b_busy;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .cs(a_cs), .mem_rd_wr(a_rd), .mask(a_mask),
        .mem_addr(a_addr), .mem_write_data(a_wd), .mem_read_data(a_rdata),
        .mem_valid(a_valid), .busy(a_busy)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset), .cs(b_cs), .mem_rd_wr(b_rd), .mask(b_mask),
        .mem_addr(b_addr), .mem_write_data(b_wd), .mem_read_data(b_rdata),
        .mem_valid(b_valid), .busy(b_busy)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endfunction

    // One request on instance inst (0: LATENCY=2, 1: LATENCY=0). Counts
    // cycles from acceptance to mem_valid and checks the pulse is single.
    task automatic req(input bit inst, input logic rd, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output int cyc);
        logic v;
        @(negedge clk);
        if (!inst) begin a_cs = 1; a_rd = rd; a_mask = m; a_addr = a; a_wd = d; end
        else       begin b_cs = 1; b_rd = rd; b_mask = m; b_addr = a; b_wd = d; end
        @(posedge clk);
        #1;
        // Drop cs and scramble the rest: the latched request must win.
        if (!inst) begin a_cs = 0; a_rd = ~rd; a_mask = ~m; a_addr = ~a; a_wd = ~d; end
        else       begin b_cs = 0; b_rd = ~rd; b_mask = ~m; b_addr = ~a; b_wd = ~d; end
        cyc = 0;
        rdata = 32'hx;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            v = inst ? b_valid : a_valid;
            if (v) begin
                rdata = inst ? b_rdata : a_rdata;
                chk("busy_in_resp", 32'(inst ? b_busy : a_busy), 32'd1);
                break;
            end
        end
        @(negedge clk);
        chk("valid_one_pulse", 32'(inst ? b_valid : a_valid), 32'd0);
        chk("busy_after_resp", 32'(inst ? b_busy : a_busy), 32'd0);
    endtask

    typedef struct {
        logic        rd;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [31:0] rd_v;
        int          cyc;
        logic [31:0] ba;

        tbl[0]  = '{1'b0, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{1'b0, 4'h5, 32'h0000_0010, 32'h11223344, 32'h0};
        tbl[3]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h0,        32'hDE22BE44};
        tbl[4]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,        32'hDE22BE44};
        tbl[5]  = '{1'b0, 4'h0, 32'h0000_0010, 32'hAAAAAAAA, 32'h0};
        tbl[6]  = '{1'b1, 4'hF, 32'h0000_0013, 32'h0,        32'hDE22BE44};
        tbl[7]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h12345678, 32'h0};
        tbl[8]  = '{1'b0, 4'hF, 32'h0000_1000, 32'hFFFFFFFF, 32'h0};
        tbl[9]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0,        32'h12345678};
        tbl[10] = '{1'b1, 4'hF, 32'h0000_1000, 32'h0,        32'h00000000};
        tbl[11] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'hA5A5A5A5, 32'h0};
        tbl[12] = '{1'b1, 4'hF, 32'h0000_0FFF, 32'h0,        32'hA5A5A5A5};
        tbl[13] = '{1'b0, 4'hF, 32'h0000_0020, 32'h00000000, 32'h0};
        tbl[14] = '{1'b1, 4'hF, 32'h0000_0020, 32'h0,        32'h00000000};

        // Reset held for 3 cycles, then 10 idle cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", 32'({a_valid, b_valid}), 32'd0);
            chk("rst_busy",  32'({a_busy, b_busy}), 32'd0);
            chk("rst_rdata", a_rdata | b_rdata, 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", {a_rdata[29:0], a_valid, a_busy}, 32'd0);
            chk("idle_outs_l0", {b_rdata[29:0], b_valid, b_busy}, 32'd0);
        end

        // Table of requests on the LATENCY=2 instance.
        for (int i = 0; i < 15; i++) begin
            req(1'b0, tbl[i].rd, tbl[i].m, tbl[i].a, tbl[i].d, rd_v, cyc);
            chk($sformatf("lat2_v%0d", i), 32'(cyc), 32'd3);
            if (tbl[i].rd) chk($sformatf("data_v%0d", i), rd_v, tbl[i].exp);
        end

        // LATENCY=0: preload two words, then back-to-back reads with cs held.
        req(1'b1, 1'b0, 4'hF, 32'h40, 32'h11111111, rd_v, cyc);
        chk("lat0_wr0", 32'(cyc), 32'd1);
        req(1'b1, 1'b0, 4'hF, 32'h44, 32'h22222222, rd_v, cyc);
        chk("lat0_wr1", 32'(cyc), 32'd1);
        @(negedge clk);
        b_cs = 1; b_rd = 1; b_mask = 4'hF; b_addr = 32'h40;
        for (int j = 0; j < 4; j++) begin
            ba = (j % 2 == 0) ? 32'h40 : 32'h44;
            @(posedge clk);
            #1 b_addr = ba ^ 32'h4;   // moves during RESP; becomes next request
            @(negedge clk);
            chk($sformatf("b2b_valid%0d", j), 32'(b_valid), 32'd1);
            chk($sformatf("b2b_data%0d", j), b_rdata,
                (ba == 32'h40) ? 32'h11111111 : 32'h22222222);
            @(negedge clk);
            chk($sformatf("b2b_gap%0d", j), 32'(b_valid), 32'd0);
        end
        b_cs = 0;
        repeat (2) @(negedge clk);

        // Reset during WAIT of a write aborts it.
        a_cs = 1; a_rd = 0; a_mask = 4'hF; a_addr = 32'h20; a_wd = 32'hCAFEF00D;
        @(posedge clk);
        #1 a_cs = 0;
        @(negedge clk);
        chk("mid_busy_wait", 32'(a_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_async", 32'({a_valid, a_busy}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_valid", 32'(a_valid), 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({a_valid, a_busy}), 32'd0);
        end
        req(1'b0, 1'b1, 4'hF, 32'h20, 32'h0, rd_v, cyc);
        chk("post_rst_lat", 32'(cyc), 32'd3);
        chk("post_rst_data", rd_v, 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
